seg_chain_driver: RTL and testbench
===================================

// Module: seg_chain_driver
// PURPOSE
//   Parametrised successor to the single-chain display shift_reg. Serialises CHAINS parallel
//   frames of WIDTH bits onto CHAINS data pins with a shared sclk/latch. Adds a programmable
//   sclk divider, bit-order select, multi-cycle latch, busy/done status and a one-deep pending
//   buffer. Sits between seven_seg/time_date_shift and the external 74HC595-style chains.
// PARAMETERS
//   WIDTH         84  bits per chain (7*12 segments); >=2
//   CHAINS        1   parallel chains sharing sclk/latch; >=1
//   DIV           1   clk cycles per sclk half-period; >=1
//   MSB_FIRST     1   1: shift bit WIDTH-1 first; 0: bit 0 first
//   LATCH_CYCLES  1   latch_o high time in clk cycles; >=1
// PORTS
//   clk_i    in   1             system clock (12.5 kHz in current top)
//   rst_i    in   1             synchronous, active-high reset
//   start_i  in   1             1-cycle request to transfer data_i
//   data_i   in   CHAINS*WIDTH  frame; chain c = data_i[c*WIDTH +: WIDTH]
//   sclk_o   out  1             shift clock; chains sample data_o on rising edge
//   data_o   out  CHAINS        serial data, one bit per chain
//   latch_o  out  1             storage-register latch pulse
//   busy_o   out  1             transfer or latch in progress
//   done_o   out  1             1-cycle pulse when a frame has been latched
// BEHAVIOUR
//   - Reset: state IDLE; sclk_o, data_o, latch_o, busy_o, done_o = 0; pending cleared; all
//     output regs flopped. Reset mid-transfer aborts immediately, no latch issued.
//   - States IDLE -> SHIFT_LO -> SHIFT_HI -> (SHIFT_LO | LATCH) -> IDLE/SHIFT_LO.
//   - IDLE + start_i (cycle 0): capture data_i into shift reg; cycle 1: busy_o=1, SHIFT_LO,
//     data_o = first bit of each chain, sclk_o=0.
//   - SHIFT_LO: sclk_o=0 for DIV cycles, then SHIFT_HI: sclk_o=1 for DIV cycles; data_o stable
//     across both. Leaving SHIFT_HI advances the shift reg (next bit per MSB_FIRST) and bit cnt.
//   - After the HI phase of bit WIDTH-1: LATCH, sclk_o=0, latch_o=1 for LATCH_CYCLES, data_o=0.
//   - LATCH exit: done_o=1 for exactly 1 cycle. No pending: IDLE, busy_o=0 in that same cycle.
//     Pending: load pending buffer, SHIFT_LO immediately, busy_o stays 1 (back-to-back frame).
//   - Frame time start_i->done_o = 1 + 2*DIV*WIDTH + LATCH_CYCLES cycles.
//   - start_i while busy_o=1 (incl. LATCH): data_i copied into pending buffer, pending=1;
//     later start_i overwrites (latest wins); never corrupts frame in flight.
//   - start_i in the done_o cycle: if FSM went IDLE it is a normal IDLE start next cycle;
//     if it chained a pending frame, it refills pending.
//   - Counters: div cnt $clog2(DIV+1) bits, bit cnt $clog2(WIDTH+1) bits; no wrap past WIDTH.
//   - start_i ignored in the reset cycle.
// STRUCTURE
//   - Shared package msf_pkg: SEG_BITS=7, DISPLAY_DIGITS=12, default WIDTH constant, state enum
//     localparams.
//   - One sub-module: seg_tick_gen (DIV counter, emits phase-end strobe, cleared on start).
//   - Shift reg CHAINS*WIDTH + pending reg CHAINS*WIDTH + 1 flag; no other storage.
// TESTING
//   1 WIDTH=8,CHAINS=2,DIV=2,MSB_FIRST=1; start data {0x3C,0xA5} -> 8 sclk rises; chain0 bits
//     1,0,1,0,0,1,0,1; chain1 0,0,1,1,1,1,0,0; latch 1 cycle; done_o at cycle 34.
//   2 Same, MSB_FIRST=0, data 0x01 -> chain0 samples 1 then seven 0s.
//   3 start_i at cycle 10 mid-frame (0x5A), again at 12 (0xFF) -> second frame follows
//     back-to-back with 0xFF, busy_o never drops, two done_o pulses.
//   4 rst_i at cycle 15 of a frame -> next cycle all outputs 0, no latch_o, no done_o;
//     fresh start completes normally.
//   5 WIDTH=84,CHAINS=1,DIV=1,LATCH_CYCLES=3 -> 84 rises, latch_o high 3 cycles, done_o at
//     cycle 172.
//   6 start_i in done_o cycle with pending empty -> new frame begins next cycle, 1-cycle busy gap.

Source files
------------

// File: rtl/msf_pkg.sv
// Shared constants and FSM state encoding for the multi-segment display path.
package msf_pkg;

  localparam int unsigned SEG_BITS       = 7;
  localparam int unsigned DISPLAY_DIGITS = 12;
  localparam int unsigned DEFAULT_WIDTH  = SEG_BITS * DISPLAY_DIGITS;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SHIFT_LO = 2'd1,
    ST_SHIFT_HI = 2'd2,
    ST_LATCH    = 2'd3
  } state_t;

endpackage

// File: rtl/seg_chain_driver_tick_gen.sv
// Phase timer: counts DIV enabled cycles and strobes on the last one of each sclk half-period.
module seg_tick_gen
  import msf_pkg::*;
#(
  parameter int unsigned DIV = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en,
  input  logic clear,
  output logic phase_end_c
);

  localparam int unsigned CNT_W = $clog2(DIV + 1);

  logic [CNT_W-1:0] cnt;

  assign phase_end_c = en && (cnt == CNT_W'(DIV - 1));

  // Restart at every phase boundary, whenever idle, and on a new frame.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear || !en || phase_end_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seg_chain_driver.sv
// Serialises CHAINS parallel frames onto 74HC595-style chains with shared sclk and latch.
module seg_chain_driver
  import msf_pkg::*;
#(
  parameter int unsigned WIDTH        = DEFAULT_WIDTH,
  parameter int unsigned CHAINS       = 1,
  parameter int unsigned DIV          = 1,
  parameter bit          MSB_FIRST    = 1'b1,
  parameter int unsigned LATCH_CYCLES = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic [CHAINS*WIDTH-1:0]   data_i,
  output logic                      sclk_o,
  output logic [CHAINS-1:0]         data_o,
  output logic                      latch_o,
  output logic                      busy_o,
  output logic                      done_o
);

  localparam int unsigned FRAME_W = CHAINS * WIDTH;
  localparam int unsigned BIT_W   = $clog2(WIDTH + 1);
  localparam int unsigned LAT_W   = $clog2(LATCH_CYCLES + 1);

  state_t             state;
  logic [FRAME_W-1:0] shreg;
  logic [FRAME_W-1:0] pend;
  logic               pend_valid;
  logic [BIT_W-1:0]   bit_cnt;
  logic [LAT_W-1:0]   lat_cnt;

  logic               phase_end_c;
  logic               tick_en_c;
  logic               latch_exit_c;
  logic               chain_c;
  logic               load_c;
  logic [FRAME_W-1:0] load_frame_c;
  logic [FRAME_W-1:0] shreg_next_c;

  // Bit that goes out first from each chain of a frame.
  function automatic logic [CHAINS-1:0] head_bits(input logic [FRAME_W-1:0] f);
    logic [CHAINS-1:0] h;
    h = '0;
    for (int unsigned c = 0; c < CHAINS; c++) begin
      h[c] = MSB_FIRST ? f[c*WIDTH + WIDTH - 1] : f[c*WIDTH];
    end
    return h;
  endfunction

  // Advance every chain by one bit toward its output end.
  function automatic logic [FRAME_W-1:0] shift_frame(input logic [FRAME_W-1:0] f);
    logic [FRAME_W-1:0] r;
    logic [WIDTH-1:0]   ch;
    r = '0;
    for (int unsigned c = 0; c < CHAINS; c++) begin
      ch = f[c*WIDTH +: WIDTH];
      if (MSB_FIRST) begin
        ch = {ch[WIDTH-2:0], 1'b0};
      end else begin
        ch = {1'b0, ch[WIDTH-1:1]};
      end
      r[c*WIDTH +: WIDTH] = ch;
    end
    return r;
  endfunction

  // Frame-level decisions; a start in the final latch cycle supersedes any buffered frame.
  always_comb begin
    tick_en_c    = (state == ST_SHIFT_LO) || (state == ST_SHIFT_HI);
    latch_exit_c = (state == ST_LATCH) && (lat_cnt == LAT_W'(LATCH_CYCLES - 1));
    chain_c      = latch_exit_c && (start_i || pend_valid);
    load_c       = ((state == ST_IDLE) && start_i) || chain_c;
    load_frame_c = ((state == ST_IDLE) || start_i) ? data_i : pend;
    shreg_next_c = shift_frame(shreg);
  end

  seg_tick_gen #(
    .DIV(DIV)
  ) u_tick (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .en         (tick_en_c),
    .clear      (load_c),
    .phase_end_c(phase_end_c)
  );

  // Transfer FSM with registered pin outputs and the one-deep pending buffer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      pend       <= '0;
      pend_valid <= 1'b0;
      bit_cnt    <= '0;
      lat_cnt    <= '0;
      sclk_o     <= 1'b0;
      data_o     <= '0;
      latch_o    <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            shreg   <= load_frame_c;
            data_o  <= head_bits(load_frame_c);
            bit_cnt <= '0;
            sclk_o  <= 1'b0;
            busy_o  <= 1'b1;
            state   <= ST_SHIFT_LO;
          end
        end
        ST_SHIFT_LO: begin
          if (phase_end_c) begin
            sclk_o <= 1'b1;
            state  <= ST_SHIFT_HI;
          end
        end
        ST_SHIFT_HI: begin
          if (phase_end_c) begin
            sclk_o <= 1'b0;
            if (bit_cnt == BIT_W'(WIDTH - 1)) begin
              bit_cnt <= BIT_W'(WIDTH);
              lat_cnt <= '0;
              latch_o <= 1'b1;
              data_o  <= '0;
              state   <= ST_LATCH;
            end else begin
              shreg   <= shreg_next_c;
              data_o  <= head_bits(shreg_next_c);
              bit_cnt <= bit_cnt + BIT_W'(1);
              state   <= ST_SHIFT_LO;
            end
          end
        end
        ST_LATCH: begin
          if (latch_exit_c) begin
            latch_o <= 1'b0;
            done_o  <= 1'b1;
            if (chain_c) begin
              shreg   <= load_frame_c;
              data_o  <= head_bits(load_frame_c);
              bit_cnt <= '0;
              state   <= ST_SHIFT_LO;
            end else begin
              busy_o <= 1'b0;
              state  <= ST_IDLE;
            end
          end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (chain_c) begin
        pend_valid <= 1'b0;
      end else if (start_i && (state != ST_IDLE)) begin
        pend       <= data_i;
        pend_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_chain_driver.sv
// Randomised bench for seg_chain_driver against a frame-timing reference model.
module tb_seg_chain_driver;

  localparam int MAXB   = 168;
  localparam int NCYC   = 6000;

  logic clk;
  logic rst_v[2];
  logic start_v[2];
  logic [15:0] din_a;
  logic [83:0] din_b;

  logic       sclk_a, latch_a, busy_a, done_a;
  logic [1:0] dout_a;
  logic       sclk_b, latch_b, busy_b, done_b;
  logic [0:0] dout_b;

  int n_tests;
  int n_fail;
  int t;

  // Model state per DUT
  bit            active[2];
  int            done_at[2];
  bit            pend_v[2];
  logic [MAXB-1:0] pend[2];
  logic [MAXB-1:0] cur[2];

  seg_chain_driver #(.WIDTH(8), .CHAINS(2), .DIV(2), .MSB_FIRST(1'b1), .LATCH_CYCLES(1)) dut_a (
    .clk_i(clk), .rst_i(rst_v[0]), .start_i(start_v[0]), .data_i(din_a),
    .sclk_o(sclk_a), .data_o(dout_a), .latch_o(latch_a), .busy_o(busy_a), .done_o(done_a));

  seg_chain_driver #(.WIDTH(84), .CHAINS(1), .DIV(1), .MSB_FIRST(1'b0), .LATCH_CYCLES(3)) dut_b (
    .clk_i(clk), .rst_i(rst_v[1]), .start_i(start_v[1]), .data_i(din_b),
    .sclk_o(sclk_b), .data_o(dout_b), .latch_o(latch_b), .busy_o(busy_b), .done_o(done_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int p_w(input int k);  return (k == 0) ? 8 : 84; endfunction
  function automatic int p_c(input int k);  return (k == 0) ? 2 : 1;  endfunction
  function automatic int p_d(input int k);  return (k == 0) ? 2 : 1;  endfunction
  function automatic bit p_m(input int k);  return (k == 0);          endfunction
  function automatic int p_l(input int k);  return (k == 0) ? 1 : 3;  endfunction

  task automatic check(input string tag, input logic [MAXB-1:0] got, input logic [MAXB-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, t, got, exp);
    end
  endtask

  initial begin
    logic [191:0]    r192;
    logic [MAXB-1:0] f;
    logic [MAXB-1:0] mask;
    logic [1:0]      e_dat;
    logic [1:0]      g_dat;
    bit e_done, e_sclk, e_lat, do_rst, do_start;
    bit g_sclk, g_lat, g_busy, g_done;
    int W, C, D, L, SH, ws, o, bi;

    n_tests = 0;
    n_fail  = 0;
    t       = -1;
    for (int k = 0; k < 2; k++) begin
      rst_v[k]   = 1'b1;
      start_v[k] = 1'b1;
      active[k]  = 1'b0;
      pend_v[k]  = 1'b0;
      done_at[k] = 0;
      pend[k]    = '0;
      cur[k]     = '0;
    end
    din_a = '1;
    din_b = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_a", MAXB'({sclk_a, dout_a, latch_a, busy_a, done_a}), MAXB'(0));
    check("rst_b", MAXB'({sclk_b, dout_b, latch_b, busy_b, done_b}), MAXB'(0));

    for (t = 0; t < NCYC; t++) begin
      for (int k = 0; k < 2; k++) begin
        W  = p_w(k); C = p_c(k); D = p_d(k); L = p_l(k);
        SH = 2 * D * W;

        // Frame completion and back-to-back chaining
        e_done = active[k] && (t == done_at[k]);
        if (e_done) begin
          if (pend_v[k]) begin
            cur[k]     = pend[k];
            pend_v[k]  = 1'b0;
            done_at[k] = t + SH + L;
          end else begin
            active[k] = 1'b0;
          end
        end

        e_sclk = 1'b0;
        e_lat  = 1'b0;
        e_dat  = '0;
        if (active[k]) begin
          ws = done_at[k] - L - SH;
          if (t >= ws && t < ws + SH) begin
            o      = t - ws;
            e_sclk = ((o / D) % 2) == 1;
            bi     = o / (2 * D);
            for (int c = 0; c < C; c++) begin
              e_dat[c] = cur[k][c*W + (p_m(k) ? (W - 1 - bi) : bi)];
            end
          end else if (t >= done_at[k] - L && t < done_at[k]) begin
            e_lat = 1'b1;
          end
        end

        if (k == 0) begin
          g_sclk = sclk_a; g_lat = latch_a; g_busy = busy_a; g_done = done_a; g_dat = dout_a;
        end else begin
          g_sclk = sclk_b; g_lat = latch_b; g_busy = busy_b; g_done = done_b; g_dat = {1'b0, dout_b};
        end
        check((k == 0) ? "done_a"  : "done_b",  MAXB'(g_done), MAXB'(e_done));
        check((k == 0) ? "busy_a"  : "busy_b",  MAXB'(g_busy), MAXB'(active[k]));
        check((k == 0) ? "sclk_a"  : "sclk_b",  MAXB'(g_sclk), MAXB'(e_sclk));
        check((k == 0) ? "latch_a" : "latch_b", MAXB'(g_lat),  MAXB'(e_lat));
        check((k == 0) ? "data_a"  : "data_b",  MAXB'(g_dat),  MAXB'(e_dat));

        // Stimulus for this cycle
        r192 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        f    = r192[MAXB-1:0];
        mask = (MAXB'(1) << (C * W)) - MAXB'(1);
        if (t == 0) f = (k == 0) ? MAXB'(16'h3CA5) : MAXB'(1);
        f = f & mask;

        do_rst = (t > 50) && ($urandom_range(0, 999) < 3);
        if (k == 0 && t == 60) do_rst = 1'b1;
        if (t == 0) begin
          do_start = 1'b1;
        end else if (e_done && !active[k]) begin
          do_start = ($urandom_range(0, 1) == 1);
        end else begin
          do_start = ($urandom_range(0, (k == 0) ? 24 : 149) == 0);
        end

        rst_v[k]   = do_rst;
        start_v[k] = do_start;
        if (k == 0) din_a = f[15:0];
        else        din_b = f[83:0];

        if (do_rst) begin
          active[k] = 1'b0;
          pend_v[k] = 1'b0;
        end else if (do_start) begin
          if (!active[k]) begin
            active[k]  = 1'b1;
            cur[k]     = f;
            done_at[k] = t + 1 + SH + L;
          end else begin
            pend[k]   = f;
            pend_v[k] = 1'b1;
          end
        end
      end
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
